// File: rtl/g711_expand.sv
// G.711 A-law/u-law expander to 13-bit sign-magnitude; G711_EXPAND_TWOS_EN adds out_lin two's-complement output.
// Latency: two register stages (capture, magnitude); one sample per cycle.
// Backpressure: lossless; in_ready depends only on registered valids and out_ready.
module g711_expand (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        law,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
`ifdef G711_EXPAND_TWOS_EN
    output logic [12:0] out_mag,
    output logic [13:0] out_lin
`else
    output logic [12:0] out_mag
`endif
);

    typedef struct packed {
        logic       law;
        logic       sign;
        logic [2:0] seg;
        logic [3:0] q;
    } s1_t;

    s1_t        s1_d;
    s1_t        s1_q;
    logic       v1;
    logic       v2;
    logic       adv1;
    logic       adv2;
    logic [7:0] x;
    logic [13:0] base;
    logic [13:0] seeded;
    logic [13:0] mag_w;

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v2;

    // Undo the line inversion: A-law toggles even bits, u-law inverts all bits.
    always_comb begin
        x         = in_code ^ (law ? 8'hD5 : 8'hFF);
        s1_d      = '0;
        s1_d.law  = law;
        s1_d.sign = x[7];
        s1_d.seg  = x[6:4];
        s1_d.q    = x[3:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1   <= 1'b0;
            s1_q <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Largest intermediate is 63 << 7 = 8064, so the result never needs saturation.
    always_comb begin
        base   = {9'd0, s1_q.q, 1'b1};
        seeded = base + 14'd32;
        mag_w  = '0;
        if (s1_q.law) begin
            if (s1_q.seg == 3'd0) begin
                mag_w = base;
            end else begin
                mag_w = seeded << (s1_q.seg - 3'd1);
            end
        end else begin
            mag_w = (seeded << s1_q.seg) - 14'd33;
        end
    end

`ifdef G711_EXPAND_TWOS_EN
    logic [13:0] lin_w;

    // A zero magnitude negates to zero, which folds u-law negative zero onto 0.
    always_comb begin
        lin_w = s1_q.sign ? (14'd0 - mag_w) : mag_w;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2       <= 1'b0;
            out_sign <= 1'b0;
            out_mag  <= '0;
`ifdef G711_EXPAND_TWOS_EN
            out_lin  <= '0;
`endif
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                out_sign <= s1_q.sign;
                out_mag  <= 13'(mag_w);
`ifdef G711_EXPAND_TWOS_EN
                out_lin  <= lin_w;
`endif
            end
        end
    end

endmodule
